clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Time-setting controller for the digital clock's hours/minutes/seconds timekeeper.
- Normally lets the timekeeper run. On mode-button presses it freezes the timekeeper, captures the current time into edit registers, and walks the user through hour, minute and second fields with up/down buttons.
- Commits the edited time back to the timekeeper with a one-cycle load, and drives per-field blink masks and a display number for the 7-segment path.

Parameters:
- T_BLINK, 50_000_000, cycles per blink half-period of the field being edited.
- T_IDLE, 1_000_000_000, cycles without a button pulse before edit aborts.
- BLINK_W, $clog2(T_BLINK), blink counter width.
- IDLE_W, $clog2(T_IDLE), idle counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_mode  in  1  single-cycle pulse, already debounced: advance field
- btn_up  in  1  single-cycle pulse: increment active field
- btn_down  in  1  single-cycle pulse: decrement active field
- cur_hours  in  8  live hours from timekeeper
- cur_minutes  in  8  live minutes
- cur_seconds  in  8  live seconds
- run_en  out  1  timekeeper count enable
- load  out  1  one-cycle load strobe to timekeeper
- load_hours  out  8  value to load
- load_minutes  out  8  value to load
- load_seconds  out  8  value to load
- edit_active  out  1  high in any edit state
- blank_mask  out  3  {hours,minutes,seconds}; 1 blanks that field's digits
- display_number  out  24  h*10000 + m*100 + s, decimal-weighted binary

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- State register: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- Reset values: state RUN; edit_h/m/s 0; blink and idle counters 0; blink phase 0.
  - Outputs at reset: run_en 1, load 0, load_* 0, edit_active 0, blank_mask 000.
- State transitions (all registered, take effect at the next edge):
  - RUN + btn_mode: go to EDIT_H. Capture cur_* into edit_h/m/s at the same edge.
  - EDIT_H + btn_mode: go to EDIT_M.
  - EDIT_M + btn_mode: go to EDIT_S.
  - EDIT_S + btn_mode: go to COMMIT.
  - COMMIT: go to RUN unconditionally after 1 cycle.
  - Any edit state, idle counter reaches T_IDLE-1: go to RUN with no load. Edits are discarded.
- Output decode (combinational from state):
  - run_en = (state==RUN).
  - edit_active = EDIT_H, EDIT_M or EDIT_S.
  - load = (state==COMMIT).
  - load_* = edit_* always.
- Latency:
  - Mode pulse in RUN at cycle n: run_en=0 from n+1.
  - Mode pulse in EDIT_S at cycle n: load=1 during n+1, run_en=1 from n+2.
- Up/down on the active field only, registered, visible the next cycle:
  - Up: if value >= MAX then 0, else value+1.
  - Down: if value == 0 or value > MAX then MAX, else value-1.
  - MAX is 23 for hours, 59 for minutes and seconds.
  - Out-of-range captured values are accepted as-is and normalised by the first up/down.
- Simultaneous pulses:
  - btn_mode wins; up/down ignored that cycle.
  - btn_up and btn_down together: both ignored, but the idle counter still resets.
  - Button pulses in RUN other than btn_mode are ignored. Button pulses in COMMIT are all ignored.
- Idle counter: counts only in edit states. Clears on any button pulse and on entry to EDIT_H.
- Blink:
  - Counter clears on edit entry, on every field change and on every up/down.
  - Phase toggles when the counter reaches T_BLINK-1, then the counter clears.
  - Phase clears to 0 (visible) whenever the counter clears for the above reasons.
  - blank_mask bit for the active field = phase; other bits 0; all 000 outside edit states.
- display_number:
  - Uses edit_* in edit states and COMMIT, cur_* in RUN.
  - Computed at 24-bit width with zero-extended operands; no truncation up to 23 59 59 (235959).
- rst mid-edit: returns to RUN with no load pulse. The timekeeper resumes from its own reset.

Decomposition:
- clock_pkg holds:
  - the state enum type (3-bit logic);
  - MAX_HOURS=8'd23 and MAX_MINSEC=8'd59;
  - field index constants F_H=2, F_M=1, F_S=0 for blank_mask.
- One sub-module, bounded_field_reg: 8-bit register with parameter MAX and inputs capture, cap_val, up, down; implements the wrap rules above. Instantiated three times.
- Blink counter, idle counter and FSM stay in clock_set_ctrl.

Test Plan (T_BLINK=4, T_IDLE=20):
- Reset, then 10 idle cycles -> run_en=1, load=0, blank_mask=000, display_number equals cur_* encoding.
- cur=12:34:56; mode, then 3×up; mode; 2×down; mode; 1×up; mode -> exactly one load cycle with load_*=15,32,57; run_en=1 two cycles after the last mode pulse.
- EDIT_H with hours=23, up -> 0; down -> 23. EDIT_M at 0, down -> 59. Captured hours=30, up -> 0.
- Enter edit, no buttons for 20 cycles -> back to RUN, run_en=1, load never asserted.
- Edit hours, no buttons -> blank_mask 000 for 4 cycles, 100 for 4, 000 for 4. An up mid-blank forces 000 the next cycle.
- btn_mode and btn_up in the same cycle in EDIT_H -> field advances to minutes, hours unchanged. rst asserted mid-EDIT_M -> RUN next cycle, load stays 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
package clock_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned DISP_W  = 24;

  localparam logic [FIELD_W-1:0] MAX_HOURS  = 8'd23;
  localparam logic [FIELD_W-1:0] MAX_MINSEC = 8'd59;

  // Bit positions within blank_mask {hours, minutes, seconds}
  localparam int unsigned F_H = 2;
  localparam int unsigned F_M = 1;
  localparam int unsigned F_S = 0;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / timekeeper / display signal bundle for clock_set_ctrl.
//   master : drives buttons and live time, observes controller outputs
//   slave  : the controller itself
interface clock_set_ctrl_if;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic [7:0]  cur_hours;
  logic [7:0]  cur_minutes;
  logic [7:0]  cur_seconds;
  logic        run_en;
  logic        load;
  logic [7:0]  load_hours;
  logic [7:0]  load_minutes;
  logic [7:0]  load_seconds;
  logic        edit_active;
  logic [2:0]  blank_mask;
  logic [23:0] display_number;

  modport master (
    output btn_mode, btn_up, btn_down, cur_hours, cur_minutes, cur_seconds,
    input  run_en, load, load_hours, load_minutes, load_seconds,
           edit_active, blank_mask, display_number
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_hours, cur_minutes, cur_seconds,
    output run_en, load, load_hours, load_minutes, load_seconds,
           edit_active, blank_mask, display_number
  );
endinterface

// File: rtl/clock_set_ctrl_bounded_field_reg.sv
// Edit register for one time field with wrap-around up/down.
//   clk, rst : clock, synchronous active-high reset
//   capture  : load cap_val (highest priority)
//   cap_val  : value to capture, accepted even if out of range
//   up, down : single-cycle adjust requests (up wins if both; caller masks)
//   value    : current field value
module bounded_field_reg #(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [7:0] cap_val,
  input  logic       up,
  input  logic       down,
  output logic [7:0] value
);

  // Out-of-range captured values get normalised by the first adjust
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 8'd0;
    end else if (capture) begin
      value <= cap_val;
    end else if (up) begin
      value <= (value >= MAX) ? 8'd0 : value + 8'd1;
    end else if (down) begin
      value <= ((value == 8'd0) || (value > MAX)) ? MAX : value - 8'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the timekeeper, edits h/m/s fields with
// up/down buttons, commits with a one-cycle load, drives blink mask and
// decimal-weighted display number.
//   clk, rst : clock, synchronous active-high reset
//   bus      : clock_set_ctrl_if slave (buttons, live time, load/display out)
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned T_BLINK = 50_000_000,
  parameter int unsigned T_IDLE  = 1_000_000_000
) (
  input  logic            clk,
  input  logic            rst,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned BLINK_W = $clog2(T_BLINK);
  localparam int unsigned IDLE_W  = $clog2(T_IDLE);

  state_t               state;
  state_t               state_nxt;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [FIELD_W-1:0]   edit_h;
  logic [FIELD_W-1:0]   edit_m;
  logic [FIELD_W-1:0]   edit_s;

  logic in_edit;
  logic btn_any;
  logic adj_ok;
  logic inc;
  logic dec;
  logic capture;
  logic idle_hit;
  logic blink_hit;
  logic blink_clr;

  assign in_edit   = (state == ST_EDIT_H) || (state == ST_EDIT_M) || (state == ST_EDIT_S);
  assign btn_any   = bus.btn_mode | bus.btn_up | bus.btn_down;
  // Mode wins over up/down; up and down together cancel
  assign adj_ok    = in_edit & ~bus.btn_mode & (bus.btn_up ^ bus.btn_down);
  assign inc       = adj_ok & bus.btn_up;
  assign dec       = adj_ok & bus.btn_down;
  assign capture   = (state == ST_RUN) & bus.btn_mode;
  assign idle_hit  = (idle_cnt == IDLE_W'(T_IDLE - 1));
  assign blink_hit = (blink_cnt == BLINK_W'(T_BLINK - 1));
  assign blink_clr = ~in_edit | bus.btn_mode | adj_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic; a button pulse in the same cycle pre-empts the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (bus.btn_mode) state_nxt = ST_EDIT_H;
      ST_EDIT_H: if (bus.btn_mode) state_nxt = ST_EDIT_M;
                 else if (idle_hit && !btn_any) state_nxt = ST_RUN;
      ST_EDIT_M: if (bus.btn_mode) state_nxt = ST_EDIT_S;
                 else if (idle_hit && !btn_any) state_nxt = ST_RUN;
      ST_EDIT_S: if (bus.btn_mode) state_nxt = ST_COMMIT;
                 else if (idle_hit && !btn_any) state_nxt = ST_RUN;
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Idle counter: runs only while editing, cleared by any button
  always_ff @(posedge clk) begin
    if (rst)                              idle_cnt <= '0;
    else if (!in_edit || btn_any || idle_hit) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // Blink counter/phase: restart visible on entry, field change or adjust
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_hit) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  bounded_field_reg #(.MAX(MAX_HOURS)) u_hours (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .cap_val (bus.cur_hours),
    .up      (inc && (state == ST_EDIT_H)),
    .down    (dec && (state == ST_EDIT_H)),
    .value   (edit_h)
  );

  bounded_field_reg #(.MAX(MAX_MINSEC)) u_minutes (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .cap_val (bus.cur_minutes),
    .up      (inc && (state == ST_EDIT_M)),
    .down    (dec && (state == ST_EDIT_M)),
    .value   (edit_m)
  );

  bounded_field_reg #(.MAX(MAX_MINSEC)) u_seconds (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .cap_val (bus.cur_seconds),
    .up      (inc && (state == ST_EDIT_S)),
    .down    (dec && (state == ST_EDIT_S)),
    .value   (edit_s)
  );

  // Output decode from registered state
  always_comb begin
    bus.run_en      = 1'b0;
    bus.load        = 1'b0;
    bus.edit_active = 1'b0;
    bus.blank_mask  = 3'b000;
    case (state)
      ST_RUN:    bus.run_en = 1'b1;
      ST_EDIT_H: begin
        bus.edit_active     = 1'b1;
        bus.blank_mask[F_H] = blink_phase;
      end
      ST_EDIT_M: begin
        bus.edit_active     = 1'b1;
        bus.blank_mask[F_M] = blink_phase;
      end
      ST_EDIT_S: begin
        bus.edit_active     = 1'b1;
        bus.blank_mask[F_S] = blink_phase;
      end
      ST_COMMIT: bus.load = 1'b1;
      default:   bus.run_en = 1'b1;
    endcase
  end

  assign bus.load_hours   = edit_h;
  assign bus.load_minutes = edit_m;
  assign bus.load_seconds = edit_s;

  // Decimal-weighted display value; live time while running, edit copy otherwise
  always_comb begin
    logic [FIELD_W-1:0] dh;
    logic [FIELD_W-1:0] dm;
    logic [FIELD_W-1:0] ds;
    dh = edit_h;
    dm = edit_m;
    ds = edit_s;
    if (state == ST_RUN) begin
      dh = bus.cur_hours;
      dm = bus.cur_minutes;
      ds = bus.cur_seconds;
    end
    bus.display_number = DISP_W'(dh) * DISP_W'(10000)
                       + DISP_W'(dm) * DISP_W'(100)
                       + DISP_W'(ds);
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (T_BLINK=4, T_IDLE=20).
module tb_clock_set_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   load_cnt;
  int   load_base;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.T_BLINK(4), .T_IDLE(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count load cycles independently of the directed sequence
  initial load_cnt = 0;
  always @(negedge clk) if (bus.load === 1'b1) load_cnt <= load_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply buttons for one clock edge; return at the following negedge
  task automatic step(input logic m, input logic u, input logic d);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hours   = h;
    bus.cur_minutes = m;
    bus.cur_seconds = s;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    set_cur(8'd12, 8'd34, 8'd56);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_run_en", 32'(bus.run_en), 32'd1);
    chk("rst_load", 32'(bus.load), 32'd0);
    chk("rst_edit_active", 32'(bus.edit_active), 32'd0);
    chk("rst_blank", 32'(bus.blank_mask), 32'd0);
    chk("rst_load_hours", 32'(bus.load_hours), 32'd0);
    rst = 1'b0;

    // Idle run
    repeat (10) @(negedge clk);
    chk("run_run_en", 32'(bus.run_en), 32'd1);
    chk("run_load", 32'(bus.load), 32'd0);
    chk("run_blank", 32'(bus.blank_mask), 32'd0);
    chk("run_display", 32'(bus.display_number), 32'd123456);

    // Full edit 12:34:56 -> 15:32:57
    step(1, 0, 0);
    chk("eh_run_en", 32'(bus.run_en), 32'd0);
    chk("eh_edit_active", 32'(bus.edit_active), 32'd1);
    chk("eh_capture_h", 32'(bus.load_hours), 32'd12);
    chk("eh_display", 32'(bus.display_number), 32'd123456);
    repeat (3) step(0, 1, 0);
    chk("eh_up3", 32'(bus.load_hours), 32'd15);
    chk("eh_display_up", 32'(bus.display_number), 32'd153456);
    step(1, 0, 0);
    repeat (2) step(0, 0, 1);
    chk("em_down2", 32'(bus.load_minutes), 32'd32);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("es_up1", 32'(bus.load_seconds), 32'd57);
    load_base = load_cnt;
    step(1, 0, 0);
    chk("commit_load", 32'(bus.load), 32'd1);
    chk("commit_run_en", 32'(bus.run_en), 32'd0);
    chk("commit_h", 32'(bus.load_hours), 32'd15);
    chk("commit_m", 32'(bus.load_minutes), 32'd32);
    chk("commit_s", 32'(bus.load_seconds), 32'd57);
    chk("commit_display", 32'(bus.display_number), 32'd153257);
    @(negedge clk);
    chk("post_commit_run_en", 32'(bus.run_en), 32'd1);
    chk("post_commit_load", 32'(bus.load), 32'd0);
    chk("post_commit_display", 32'(bus.display_number), 32'd123456);
    repeat (3) @(negedge clk);
    chk("commit_load_count", 32'(load_cnt - load_base), 32'd1);

    // Wrap boundaries
    set_cur(8'd23, 8'd0, 8'd0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("h23_up", 32'(bus.load_hours), 32'd0);
    step(0, 0, 1);
    chk("h0_down", 32'(bus.load_hours), 32'd23);
    step(0, 1, 1);
    chk("h_updown_cancel", 32'(bus.load_hours), 32'd23);
    step(1, 0, 0);
    step(0, 0, 1);
    chk("m0_down", 32'(bus.load_minutes), 32'd59);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("wrap_back_run", 32'(bus.run_en), 32'd1);
    set_cur(8'd30, 8'd0, 8'd0);
    step(1, 0, 0);
    chk("h30_capture", 32'(bus.load_hours), 32'd30);
    step(0, 1, 0);
    chk("h30_up", 32'(bus.load_hours), 32'd0);

    // Idle timeout aborts without load
    load_base = load_cnt;
    repeat (19) @(negedge clk);
    chk("timeout_still_edit", 32'(bus.edit_active), 32'd1);
    @(negedge clk);
    chk("timeout_run_en", 32'(bus.run_en), 32'd1);
    chk("timeout_edit_active", 32'(bus.edit_active), 32'd0);
    chk("timeout_display", 32'(bus.display_number), 32'd300000);
    repeat (2) @(negedge clk);
    chk("timeout_no_load", 32'(load_cnt - load_base), 32'd0);

    // Blink pattern on hours
    set_cur(8'd12, 8'd34, 8'd56);
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("blink_%0d", i), 32'(bus.blank_mask),
          (i >= 4 && i < 8) ? 32'd4 : 32'd0);
      @(negedge clk);
    end
    chk("blink_blank_again", 32'(bus.blank_mask), 32'd4);
    step(0, 1, 0);
    chk("blink_up_visible", 32'(bus.blank_mask), 32'd0);
    chk("blink_up_value", 32'(bus.load_hours), 32'd13);

    // Mode beats up; reset mid-edit
    load_base = load_cnt;
    step(1, 1, 0);
    chk("modeup_edit_active", 32'(bus.edit_active), 32'd1);
    chk("modeup_hours", 32'(bus.load_hours), 32'd13);
    chk("modeup_minutes", 32'(bus.load_minutes), 32'd34);
    chk("modeup_blank", 32'(bus.blank_mask), 32'd0);
    repeat (4) @(negedge clk);
    chk("em_blink_minutes", 32'(bus.blank_mask), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_run_en", 32'(bus.run_en), 32'd1);
    chk("midrst_edit_active", 32'(bus.edit_active), 32'd0);
    chk("midrst_load", 32'(bus.load), 32'd0);
    chk("midrst_hours", 32'(bus.load_hours), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_load", 32'(load_cnt - load_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
